// File: rtl/spill_flush_sched_pkg.sv
// Shared types and constants for the spill/flush round-robin scheduler.
// Holds the FSM state encoding, stat counter width and a saturating increment.
package spill_flush_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } state_e;

  localparam int unsigned StatW = 16;
  localparam logic [StatW-1:0] StatMax = 16'hFFFF;

  function automatic logic [StatW-1:0] sat_inc(
    input logic [StatW-1:0] v
  );
    return (v == StatMax) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spill_flush_sched_rr_pick.sv
// Rotate-and-find-first picker: first set valid at or after ptr_i, wrapping.
// Ports: valid_i/ptr_i in; grant_o (index), any_o (some valid set) out.
module spill_flush_sched_rr_pick #(
  parameter  int unsigned NumIn = 4,
  localparam int unsigned IdxW  = $clog2(NumIn)
) (
  input  logic [NumIn-1:0] valid_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [IdxW-1:0]  grant_o,
  output logic             any_o
);

  logic [IdxW-1:0] idx;
  logic            found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      idx = IdxW'((32'(ptr_i) + k) % NumIn);
      if (!found && valid_i[idx]) begin
        found   = 1'b1;
        grant_o = idx;
      end
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/spill_flush_rr_scheduler.sv
// Round-robin merge of NumIn streams onto one flushable spill register,
// plus a flush sequencer (flush held FlushCycles, then one-cycle ack).
// Ports: clk_i, rst_i (sync, high); inp_valid/ready/data per requester;
// spill_valid/ready/data/idx/flush to the spill; flush_req_i/flush_ack_o;
// stat_cnt_o per-requester grant counters (SPILL_FLUSH_SCHED_STATS_EN).
module spill_flush_rr_scheduler
  import spill_flush_sched_pkg::*;
#(
  parameter  int unsigned NumIn       = 4,
  parameter  type         T           = logic,
  parameter  int unsigned FlushCycles = 1,
  localparam int unsigned IdxW        = $clog2(NumIn)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumIn-1:0]            inp_valid_i,
  output logic [NumIn-1:0]            inp_ready_o,
  input  T     [NumIn-1:0]            inp_data_i,
  output logic                        spill_valid_o,
  input  logic                        spill_ready_i,
  output T                            spill_data_o,
  output logic [IdxW-1:0]             spill_idx_o,
  output logic                        spill_flush_o,
  input  logic                        flush_req_i,
  output logic                        flush_ack_o,
  output logic [NumIn-1:0][StatW-1:0] stat_cnt_o
);

  localparam int unsigned CntW =
    (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
  localparam logic [CntW-1:0] FcLast = CntW'(FlushCycles - 1);

  state_e          state_q;
  logic [CntW-1:0] fcnt_q;
  logic            flush_q;
  logic            ack_q;
  logic [IdxW-1:0] ptr_q;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;

  logic [IdxW-1:0] pick;
  logic            any_v;
  logic [IdxW-1:0] grant;
  logic            idle;
  logic            vld;
  logic            hs;
  logic            go_flush;

  spill_flush_sched_rr_pick #(
    .NumIn (NumIn)
  ) u_pick (
    .valid_i (inp_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick),
    .any_o   (any_v)
  );

  // A stalled beat keeps its source until accepted; a dropped
  // locked valid falls back to the normal pick.
  assign grant = (lock_q && inp_valid_i[lock_idx_q])
               ? lock_idx_q : pick;

  assign idle     = (state_q == IDLE);
  assign vld      = idle && any_v && !flush_req_i;
  assign hs       = vld && spill_ready_i;
  assign go_flush = idle && flush_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      flush_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (flush_req_i) begin
            state_q <= FLUSH;
            fcnt_q  <= '0;
            flush_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt_q == FcLast) begin
            state_q <= ACK;
            flush_q <= 1'b0;
            ack_q   <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (go_flush) begin
      lock_q <= 1'b0;
    end else if (hs) begin
      ptr_q  <= (grant == IdxW'(NumIn - 1)) ? '0 : grant + 1'b1;
      lock_q <= 1'b0;
    end else if (vld) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant;
    end
  end

  always_comb begin
    inp_ready_o = '0;
    if (!rst_i && hs) inp_ready_o[grant] = 1'b1;
  end

  assign spill_valid_o = !rst_i && vld;
  assign spill_data_o  = rst_i ? '0 : inp_data_i[grant];
  assign spill_idx_o   = rst_i ? '0 : grant;
  assign spill_flush_o = !rst_i && flush_q;
  assign flush_ack_o   = !rst_i && ack_q;

`ifdef SPILL_FLUSH_SCHED_STATS_EN
  logic [NumIn-1:0][StatW-1:0] stat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == ACK) begin
      stat_q <= '0;
    end else if (hs) begin
      stat_q[grant] <= sat_inc(stat_q[grant]);
    end
  end

  assign stat_cnt_o = rst_i ? '0 : stat_q;
`else
  assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_spill_flush_rr_scheduler.sv
// Bench for spill_flush_rr_scheduler: directed cases plus random
// traffic scored against a per-source in-order beat model.
module tb_spill_flush_rr_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      vld;
  logic [3:0]      rdy_o;
  logic [3:0][7:0] dat;
  logic            s_valid;
  logic            s_ready;
  logic [7:0]      s_data;
  logic [1:0]      s_idx;
  logic            s_flush;
  logic            freq;
  logic            ack;
  logic [3:0][15:0] stat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spill_flush_rr_scheduler #(
    .NumIn       (4),
    .T           (logic [7:0]),
    .FlushCycles (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .inp_valid_i   (vld),
    .inp_ready_o   (rdy_o),
    .inp_data_i    (dat),
    .spill_valid_o (s_valid),
    .spill_ready_i (s_ready),
    .spill_data_o  (s_data),
    .spill_idx_o   (s_idx),
    .spill_flush_o (s_flush),
    .flush_req_i   (freq),
    .flush_ack_o   (ack),
    .stat_cnt_o    (stat)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic r,
                       input logic f);
    vld = v; s_ready = r; freq = f;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit check_out);
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b1);
    if (check_out) begin
      chk("rst_valid", 32'(s_valid), 0);
      chk("rst_ready", 32'(rdy_o), 0);
      chk("rst_flush", 32'(s_flush), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_idx", 32'(s_idx), 0);
      chk("rst_data", 32'(s_data), 0);
      chk("rst_stat", 32'(stat[1]), 0);
    end
    tick();
    rst = 1'b0;
  endtask

  function automatic int rr_first(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // reference model state
  int m_phase;
  int m_fcnt;
  int m_ptr;
  int m_lock;
  int seq [4];
  int mstat [4];
  logic [3:0] hs_last;

  initial begin
    rst = 1'b1; vld = '0; s_ready = 1'b0; freq = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = 8'hA0 + 8'(i);
    tick();

    // reset state
    do_reset(1'b1);

    // plain rotation
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b1, 1'b0);
      chk("rot_valid", 32'(s_valid), 1);
      chk("rot_idx", 32'(s_idx), 32'(k % 4));
      chk("rot_ready", 32'(rdy_o), 32'(1 << (k % 4)));
      tick();
    end

    // stall lock
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      dat[2] = 8'h50 + 8'(k);
      drive(4'b0101, 1'b0, 1'b0);
      chk("lock_idx", 32'(s_idx), 0);
      chk("lock_data", 32'(s_data), 32'(dat[0]));
      chk("lock_ready", 32'(rdy_o), 0);
      tick();
    end
    drive(4'b0101, 1'b1, 1'b0);
    chk("lock_hs", 32'(rdy_o), 32'b0001);
    tick();
    drive(4'b0101, 1'b0, 1'b0);
    chk("next_idx", 32'(s_idx), 2);
    tick();
    drive(4'b0111, 1'b0, 1'b0);
    chk("hold_not1", 32'(s_idx), 2);
    chk("hold_data", 32'(s_data), 32'(dat[2]));
    tick();
    drive(4'b0111, 1'b1, 1'b0);
    chk("hold_hs", 32'(rdy_o), 32'b0100);
    tick();

    // flush sequence
    do_reset(1'b0);
    drive(4'b1111, 1'b1, 1'b1);
    chk("fl_entry_v", 32'(s_valid), 0);
    chk("fl_entry_r", 32'(rdy_o), 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(4'b1111, 1'b1, 1'b1);
      chk("fl_flush", 32'(s_flush), 1);
      chk("fl_valid", 32'(s_valid), 0);
      chk("fl_ready", 32'(rdy_o), 0);
      chk("fl_noack", 32'(ack), 0);
      tick();
    end
    drive(4'b1111, 1'b1, 1'b0);
    chk("fl_ack", 32'(ack), 1);
    chk("fl_ack_fl", 32'(s_flush), 0);
    chk("fl_ack_v", 32'(s_valid), 0);
    tick();
    drive(4'b1111, 1'b1, 1'b0);
    chk("fl_done_v", 32'(s_valid), 1);
    chk("fl_done_i", 32'(s_idx), 0);
    chk("fl_done_a", 32'(ack), 0);
    tick();

    // reset mid-flush
    do_reset(1'b0);
    drive(4'b0010, 1'b1, 1'b0);
    tick();
    drive(4'b1111, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b0);
    chk("mrst_flush", 32'(s_flush), 0);
    chk("mrst_valid", 32'(s_valid), 0);
    chk("mrst_ready", 32'(rdy_o), 0);
    tick();
    rst = 1'b0;
    drive(4'b1111, 1'b1, 1'b0);
    chk("mrst_fl2", 32'(s_flush), 0);
    chk("mrst_ack", 32'(ack), 0);
    chk("mrst_v", 32'(s_valid), 1);
    chk("mrst_ptr", 32'(s_idx), 0);
    tick();

`ifdef SPILL_FLUSH_SCHED_STATS_EN
    do_reset(1'b0);
    vld = 4'b0010; s_ready = 1'b1; freq = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    drive(4'b0010, 1'b1, 1'b0);
    chk("stat_sat", 32'(stat[1]), 32'hFFFF);
    chk("stat_other", 32'(stat[0]), 0);
    tick();
    drive(4'b0000, 1'b1, 1'b1);
    tick();
    repeat (3) begin
      drive(4'b0000, 1'b1, 1'b0);
      tick();
    end
    drive(4'b0000, 1'b1, 1'b0);
    chk("stat_clr", 32'(stat[1]), 0);
    tick();
`endif

    // random traffic
    do_reset(1'b0);
    m_phase = 0; m_fcnt = 0; m_ptr = 0; m_lock = -1;
    hs_last = '0;
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0; mstat[i] = 0;
    end
    vld = '0;
    for (int c = 0; c < 3000; c++) begin
      int g;
      logic ev;
      logic [3:0] er;
      logic [7:0] ed;
      for (int i = 0; i < 4; i++) begin
        if (!vld[i] || hs_last[i])
          vld[i] = ($urandom_range(0, 3) != 0);
        dat[i] = {2'(i), 6'(seq[i])};
      end
      s_ready = ($urandom_range(0, 9) < 7);
      case (m_phase)
        0: freq = ($urandom_range(0, 19) == 0);
        1: freq = ($urandom_range(0, 1) == 1);
        default: freq = ($urandom_range(0, 4) == 0);
      endcase
      @(negedge clk);

      g = -1; ev = 1'b0;
      if (m_phase == 0) begin
        if (m_lock >= 0 && vld[m_lock]) g = m_lock;
        else g = rr_first(vld, m_ptr);
        ev = (g >= 0) && !freq;
      end
      er = (ev && s_ready) ? 4'(1 << g) : 4'b0;
      chk("r_valid", 32'(s_valid), 32'(ev));
      chk("r_ready", 32'(rdy_o), 32'(er));
      chk("r_flush", 32'(s_flush), 32'(m_phase == 1));
      chk("r_ack", 32'(ack), 32'(m_phase == 2));
      chk("r_overlap", 32'(s_valid & s_flush), 0);
      for (int i = 0; i < 4; i++) begin
`ifdef SPILL_FLUSH_SCHED_STATS_EN
        chk("r_stat", 32'(stat[i]), 32'(mstat[i]));
`else
        chk("r_stat", 32'(stat[i]), 0);
`endif
      end
      hs_last = er;
      if (ev) begin
        ed = {2'(g), 6'(seq[g])};
        chk("r_idx", 32'(s_idx), 32'(g));
        chk("r_data", 32'(s_data), 32'(ed));
        if (s_ready) begin
          seq[g]++;
          if (mstat[g] < 65535) mstat[g]++;
          m_ptr  = (g + 1) % 4;
          m_lock = -1;
        end else begin
          m_lock = g;
        end
      end
      case (m_phase)
        0: if (freq) begin
          m_phase = 1; m_fcnt = 0; m_lock = -1;
        end
        1: begin
          m_fcnt++;
          if (m_fcnt == 2) m_phase = 2;
        end
        default: begin
          m_phase = 0;
          for (int i = 0; i < 4; i++) mstat[i] = 0;
        end
      endcase
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
